r_ctrl_sequencer: RTL

R_CTRL_SEQUENCER -- requirements
Module: r_ctrl_sequencer

---
 rtl/r_ctrl_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/r_ctrl_sequencer.sv
// r_ctrl_sequencer: expands one accepted activation beat into read-line control beats (one beat, or bit-planes in mode 011).
// Latency: first output beat valid the cycle after acceptance; serial planes advance one per output handshake.
// Backpressure: outputs hold while out_valid && !out_ready; in_ready only in IDLE or on the final-beat handshake.
// Optional macro RCTRL_ZERO_SKIP_EN: serial mode skips planes whose bit is 0 in every channel (plane AW-1 always sent).
module r_ctrl_sequencer #(
  parameter int CH = 8,
  parameter int AW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            mode,
  input  logic [CH-1:0]         zero,
  input  logic [CH-1:0]         neg,
  input  logic [CH*AW-1:0]      act,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*AW-1:0]      r_ctrl,
  output logic [CH*AW-1:0]      r_ctrl_b,
  output logic [$clog2(AW)-1:0] out_plane,
  output logic                  out_last
);

  localparam int              PW          = $clog2(AW);
  localparam int              W           = CH * AW;
  localparam logic [PW-1:0]   LAST_PLANE  = PW'(AW - 1);
  localparam logic [2:0]      MODE_SERIAL = 3'b011;

  typedef enum logic [1:0] {IDLE, EMIT, SERIAL} state_t;

  state_t          state_q, state_d;
  logic [2:0]      mode_q;
  logic [CH-1:0]   zero_q, neg_q;
  logic [W-1:0]    act_q;
  logic [PW-1:0]   plane_q, plane_first, plane_next;
  logic            accept, out_hs, last_hs;

  assign out_hs   = out_valid && out_ready;
  assign last_hs  = out_hs && out_last;
  // Reset gates in_ready so nothing is accepted while rst_n is low.
  assign in_ready = rst_n && ((state_q == IDLE) || last_hs);
  assign accept   = in_valid && in_ready;

`ifdef RCTRL_ZERO_SKIP_EN
  // Bit k is set when any channel has activation bit k set; top plane always present.
  function automatic logic [AW-1:0] plane_mask(input logic [W-1:0] a);
    logic [AW-1:0] m;
    m = '0;
    for (int c = 0; c < CH; c++) m = m | a[c*AW +: AW];
    m[AW-1] = 1'b1;
    return m;
  endfunction

  logic [AW-1:0] in_mask, q_mask;
  assign in_mask = plane_mask(act);
  assign q_mask  = plane_mask(act_q);

  // Lowest populated plane of the incoming beat, and next populated plane above the current one.
  always_comb begin
    plane_first = LAST_PLANE;
    plane_next  = LAST_PLANE;
    for (int k = AW - 2; k >= 0; k--) begin
      if (in_mask[k]) plane_first = PW'(k);
      if (q_mask[k] && (k > int'(plane_q))) plane_next = PW'(k);
    end
  end
`else
  // Every plane is emitted in order starting from plane 0.
  always_comb begin
    plane_first = '0;
    plane_next  = plane_q + 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a new accept wins over returning to IDLE so back-to-back ops have no bubble.
  always_comb begin
    state_d = state_q;
    if (accept)       state_d = (mode == MODE_SERIAL) ? SERIAL : EMIT;
    else if (last_hs) state_d = IDLE;
  end

  // Capture the operation on acceptance; step the plane on each non-final serial handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= '0;
      zero_q  <= '0;
      neg_q   <= '0;
      act_q   <= '0;
      plane_q <= '0;
    end else if (accept) begin
      mode_q  <= mode;
      zero_q  <= zero;
      neg_q   <= neg;
      act_q   <= act;
      plane_q <= (mode == MODE_SERIAL) ? plane_first : '0;
    end else if ((state_q == SERIAL) && out_hs && !out_last) begin
      plane_q <= plane_next;
    end
  end

  // Output decode purely from registered state, so outputs are stable during stalls.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_plane = '0;
    r_ctrl    = '0;
    r_ctrl_b  = '0;
    case (state_q)
      EMIT: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        for (int c = 0; c < CH; c++) begin
          if ((mode_q == 3'b000) || (mode_q == 3'b001)) begin
            if (zero_q[c]) begin
              r_ctrl[c*AW +: AW]   = '0;
              r_ctrl_b[c*AW +: AW] = '0;
            end else if (neg_q[c]) begin
              r_ctrl_b[c*AW +: AW] = '1;
            end else begin
              r_ctrl[c*AW +: AW]   = '1;
            end
          end else begin
            r_ctrl_b[c*AW +: AW] = act_q[c*AW +: AW];
            r_ctrl[c*AW +: AW]   = ~act_q[c*AW +: AW];
          end
        end
      end
      SERIAL: begin
        out_valid = 1'b1;
        out_last  = (plane_q == LAST_PLANE);
        out_plane = plane_q;
        for (int c = 0; c < CH; c++) begin
          r_ctrl_b[c*AW +: AW] = {AW{act_q[c*AW + int'(plane_q)]}};
          r_ctrl[c*AW +: AW]   = {AW{~act_q[c*AW + int'(plane_q)]}};
        end
      end
      default: ;
    endcase
  end

endmodule
